// File: rtl/asmi_arbiter_if.sv
// Requester and ASMI-side signal bundle for asmi_arbiter.
// The master modport is the requester/ASMI environment. The slave modport is the arbiter.
interface asmi_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [23:0] asmi_addr;
    logic        asmi_wren;
    logic        asmi_sector_erase;
    logic        asmi_write;
    logic        asmi_read;
    logic        asmi_busy;

    modport master (
        output req, lock, op0, op1, addr0, addr1, asmi_busy,
        input  gnt, done, err, asmi_addr, asmi_wren, asmi_sector_erase, asmi_write, asmi_read
    );

    modport slave (
        input  req, lock, op0, op1, addr0, addr1, asmi_busy,
        output gnt, done, err, asmi_addr, asmi_wren, asmi_sector_erase, asmi_write, asmi_read
    );
endinterface

// File: rtl/asmi_arbiter.sv
// Two-requester round-robin arbiter in front of an ASMI flash controller.
// It grants one requester, issues one erase, write or read strobe, and tracks busy to completion.
module asmi_arbiter #(
    parameter int unsigned TIMEOUT   = 25000000,
    parameter int unsigned RISE_WAIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    asmi_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StGrant, StIssue, StWaitRise, StWaitFall, StDone, StError
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;    // index of the requester owning the operation
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] cnt_q, cnt_d;

    logic        win;
    logic        cap_idx;
    logic [1:0]  cap_op;
    logic [23:0] cap_addr;
    logic [1:0]  sel_oh;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = bus.req[1];
        end
    end

    assign cap_idx  = (state_q == StDone) ? sel_q : win;
    assign cap_op   = cap_idx ? bus.op1 : bus.op0;
    assign cap_addr = cap_idx ? bus.addr1 : bus.addr0;
    assign sel_oh   = sel_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00 && !bus.asmi_busy) begin
                    state_d = StGrant;
                    sel_d   = cap_idx;
                    gnt_d   = cap_idx ? 2'b10 : 2'b01;
                    op_d    = cap_op;
                    addr_d  = cap_addr;
                end
            end
            StGrant: begin
                last_d = sel_q;
                if (op_q == 2'b11) begin
                    state_d = StError;
                    gnt_d   = 2'b00;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitRise;
                cnt_d   = '0;
            end
            StWaitRise: begin
                if (bus.asmi_busy) begin
                    state_d = StWaitFall;
                    cnt_d   = '0;
                end else if (cnt_q == 32'(RISE_WAIT - 1)) begin
                    // Busy never rose: treat as a fast completion.
                    state_d = StDone;
                    gnt_d   = 2'b00;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitFall: begin
                if (!bus.asmi_busy) begin
                    state_d = StDone;
                    gnt_d   = 2'b00;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    state_d = StError;
                    gnt_d   = 2'b00;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                if (bus.lock[sel_q] && bus.req[sel_q]) begin
                    state_d = StGrant;
                    gnt_d   = sel_oh;
                    op_d    = cap_op;
                    addr_d  = cap_addr;
                end else begin
                    state_d = StIdle;
                end
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            op_q    <= 2'b00;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.gnt               = gnt_q;
        bus.asmi_addr         = addr_q;
        bus.done              = (state_q == StDone) ? sel_oh : 2'b00;
        bus.err               = (state_q == StError) ? sel_oh : 2'b00;
        bus.asmi_sector_erase = 1'b0;
        bus.asmi_write        = 1'b0;
        bus.asmi_read         = 1'b0;
        bus.asmi_wren         = 1'b0;
        if (state_q == StIssue) begin
            bus.asmi_sector_erase = (op_q == 2'b00);
            bus.asmi_write        = (op_q == 2'b01);
            bus.asmi_read         = (op_q == 2'b10);
            bus.asmi_wren         = (op_q == 2'b00) || (op_q == 2'b01);
        end
    end

endmodule

// File: doc/asmi_arbiter.md
ASMI_ARBITER -- requirements
Module: asmi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 25000000: maximum cycles in WAIT_FALL before error.
REQ-002 SHALL have parameter RISE_WAIT, default 8: maximum cycles in WAIT_RISE for asmi_busy to assert.
REQ-003 SHALL have ports:
  clock  in  1  single clock; all state updates on rising edge
  reset  in  1  asynchronous, active-high
  req  in  2  per-requester operation request, level
  lock  in  2  per-requester hold-grant across consecutive operations
  op0, op1  in  2 each  operation: 00 sector erase, 01 page write, 10 read, 11 reserved
  addr0, addr1  in  24 each  flash address per requester
  gnt  out  2  one-hot grant, held for the whole operation
  done  out  2  one-cycle completion pulse to the granted requester
  err  out  2  one-cycle error pulse (timeout or reserved op)
  asmi_addr  out  24  address to ASMI
  asmi_wren  out  1  write enable to ASMI
  asmi_sector_erase  out  1  erase strobe
  asmi_write  out  1  page-write strobe
  asmi_read  out  1  read strobe
  asmi_busy  in  1  ASMI busy

Function
REQ-004 SHALL implement states IDLE, GRANT, ISSUE, WAIT_RISE, WAIT_FALL, DONE, ERROR.
REQ-005 IDLE: SHALL stay while req==00 or asmi_busy==1; otherwise SHALL go to GRANT.
REQ-006 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not served last; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-007 GRANT: gnt SHALL go one-hot for the winner, and op/addr SHALL be captured into internal registers; later op/addr changes SHALL NOT affect the operation in flight.
REQ-008 GRANT with captured op==11: SHALL go to ERROR without driving any ASMI strobe.
REQ-009 ISSUE: SHALL drive for exactly one cycle the strobe selected by the op (sector_erase, write, or read), plus asmi_wren=1 for erase/write and asmi_wren=0 for read, then go to WAIT_RISE.
REQ-010 asmi_addr SHALL equal the captured address from GRANT until the next GRANT.
REQ-011 WAIT_RISE: asmi_busy==1 -> WAIT_FALL; after RISE_WAIT cycles without busy -> DONE, treated as a fast completion.
REQ-012 WAIT_FALL: asmi_busy==0 -> DONE; 32-bit counter reaching TIMEOUT -> ERROR; counter SHALL clear on entry.
REQ-013 DONE: SHALL pulse done[g] for one cycle; if lock[g]==1 and req[g]==1, SHALL return to GRANT for the same requester, bypassing arbitration; otherwise SHALL clear gnt and go to IDLE.
REQ-014 ERROR: SHALL pulse err[g] for one cycle, SHALL ignore lock, SHALL clear gnt, and SHALL go to IDLE.
REQ-015 done and err SHALL never be asserted together; at most one bit of gnt/done/err SHALL be high at a time.
REQ-016 A requester dropping req mid-operation SHALL NOT abort the operation; the done/err pulse SHALL still be issued.
REQ-017 asmi_busy high on entering IDLE SHALL block a new grant until it falls, even when the holder is locked.
REQ-018 The last-served pointer SHALL update in GRANT.

Reset
REQ-019 reset SHALL force, immediately and asynchronously, IDLE state; gnt, done, err = 00; asmi_addr = 0; all ASMI strobes and asmi_wren = 0; counters = 0; last-served = 1.
REQ-020 Reset mid-operation SHALL abandon the operation with no done/err pulse; after release, behaviour SHALL be as from power-up.

Verification
REQ-021 req=01, op0=00, addr0=0x1F0000, busy high 3 cycles after strobe for 100 cycles -> gnt=01, one-cycle sector_erase+wren, asmi_addr=0x1F0000, done[0] one cycle after busy falls.
REQ-022 req=11 held, both op=10 -> grants alternate 01,10,01,10; first grant is 01; each read shows wren=0.
REQ-023 lock0=1, req0=1, req1=1, op0=01 -> requester 0 gets back-to-back page writes with no grant to requester 1 until lock0 drops.
REQ-024 TIMEOUT=50, busy stuck high after strobe -> err[0] pulse 50 cycles after WAIT_FALL entry, gnt=00, no done pulse, then IDLE blocks until busy falls.
REQ-025 op1=11 with req=10 -> err[1] pulse, no ASMI strobe; reset asserted in WAIT_FALL -> all outputs 0 the same cycle, no done/err after release.
